// File: rtl/spi_regif_pkg.sv
// Shared types and widths for the SPI slave register interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_regif_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int RW_BIT = 7;   // bit of the command byte that selects read (1) / write (0)

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        RD_FETCH = 2'd2,
        DATA     = 2'd3
    } regif_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the async SPI pins into clk100 and detects SCLK / CS edges.
// Latency: SYNC_STAGES flops to the synced levels; edge pulses are valid in the same cycle.
// Backpressure: none, free-running.
// Ports: clk100/rstn clock and async reset; sclk_i/csn_i/mosi_i raw pins;
//        sclk_rise/sclk_fall/csn_fall/csn_rise one-cycle pulses; csn_s/mosi_s synced levels.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk100,
    input  logic rstn,
    input  logic sclk_i,
    input  logic csn_i,
    input  logic mosi_i,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_s,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   csn_d;
    logic                   sclk_s;

    // CS resets to "asserted" (0) on purpose: if the master already holds CS low
    // when reset releases, no synthetic falling edge is seen, so the FSM waits for
    // a genuine new frame. If CS is high, the resulting rise is harmless in IDLE.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            csn_sync  <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0],  csn_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            csn_d     <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign csn_fall  = ~csn_s  &  csn_d;
    assign csn_rise  =  csn_s  & ~csn_d;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave decoding {rw,addr} + data byte frames into register read/write strobes.
// Latency: strobes one cycle after the synced 8th SCLK rise; read data on MISO two cycles after rd_en_o.
// Backpressure: none; the register bank must accept wr_en_o and answer rd_en_o one cycle later.
// Ports: clk100/rstn; sclk_i/csn_i/mosi_i/miso_o SPI pins; wr_en_o/rd_en_o/addr_o/wdata_o/rdata_i
//        register bank side; busy_o frame open; frame_err_o pulse on CS rise with a partial byte.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_INC    = 1'b1
) (
    input  logic              clk100,
    input  logic              rstn,
    input  logic              sclk_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o,
    output logic              frame_err_o
);

    logic sclk_rise, sclk_fall, csn_s, csn_fall, csn_rise, mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk100    (clk100),
        .rstn      (rstn),
        .sclk_i    (sclk_i),
        .csn_i     (csn_i),
        .mosi_i    (mosi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_s     (csn_s),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .mosi_s    (mosi_s)
    );

    regif_state_t      state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_byte;
    logic              rw_q;
    logic              skip_fall_q;
    logic              rd_pend_q;     // rd_en_o delayed: rdata_i is valid in this cycle
    logic              bit_rise;
    logic              byte_done;
    logic              wr_en_d, rd_en_d, frame_err_d;

    // CS high has priority, so an SCLK edge coinciding with the synced CS rise is dropped.
    assign bit_rise  = sclk_rise & ~csn_s & (state_q != IDLE);
    assign byte_done = bit_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sr_q[DATA_W-2:0], mosi_s};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (csn_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (csn_fall)  state_d = CMD;
                CMD:      if (byte_done) state_d = rx_byte[RW_BIT] ? RD_FETCH : DATA;
                RD_FETCH:                state_d = DATA;
                DATA:     if (byte_done && rw_q) state_d = RD_FETCH;
                default:                 state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs (next values of the registered strobes) ----------------
    always_comb begin
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        frame_err_d = csn_rise & (state_q != IDLE) & (bit_cnt_q != 3'd0);
        if (!csn_s) begin
            case (state_q)
                CMD: begin
                    rd_en_d = byte_done & rx_byte[RW_BIT];
                end
                DATA: begin
                    wr_en_d = byte_done & ~rw_q;
                    rd_en_d = byte_done &  rw_q;
                end
                default: begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                end
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            wr_en_o     <= 1'b0;
            rd_en_o     <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rw_q        <= 1'b0;
            skip_fall_q <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            wr_en_o     <= wr_en_d;
            rd_en_o     <= rd_en_d;
            frame_err_o <= frame_err_d;
            rd_pend_q   <= rd_en_o;
            busy_o      <= ~csn_s & (state_d != IDLE);

            // Held at zero outside a frame, so a new frame always starts on bit 0.
            if (csn_s || state_q == IDLE) begin
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (bit_rise) begin
                rx_sr_q <= rx_byte;
            end

            if (wr_en_d) begin
                wdata_o <= rx_byte;
            end

            // Writes advance the address the cycle after the strobe so that wr_en_o
            // sees the address the byte was aimed at; reads advance together with
            // the next rd_en_o so the prefetch targets addr+1.
            if (state_q == CMD && byte_done) begin
                rw_q   <= rx_byte[RW_BIT];
                addr_o <= rx_byte[ADDR_W-1:0];
            end else if (state_q == DATA && byte_done && rw_q && AUTO_INC) begin
                addr_o <= addr_o + 7'd1;
            end else if (wr_en_o && AUTO_INC) begin
                addr_o <= addr_o + 7'd1;
            end

            // A fresh load already drives the MSB, so the fall that follows a byte
            // boundary must not shift it away.
            if (rd_pend_q) begin
                tx_sr_q     <= rdata_i;
                skip_fall_q <= 1'b1;
            end else if (sclk_fall && !csn_s && state_q == DATA) begin
                if (skip_fall_q) begin
                    skip_fall_q <= 1'b0;
                end else begin
                    tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign miso_o = (state_q == DATA) & rw_q & tx_sr_q[DATA_W-1];

endmodule
